// File: rtl/conv1d_cfu_pkg.sv
// Shared constants, CFU command codes and sequencer state encoding for the
// conv1d CFU command initiator.
package conv1d_cfu_pkg;

   localparam int INT32_SIZE         = 32;
   localparam int KERNEL_LENGTH      = 8;
   localparam int MAX_INPUT_CHANNELS = 128;
   localparam int ADDR_W             = 16;
   // Widest element count a load phase can stream: KERNEL_LENGTH * MAX_INPUT_CHANNELS.
   localparam int CNT_W              = 11;

   localparam logic [6:0] CMD_WR_INPUT   = 7'd10;
   localparam logic [6:0] CMD_WR_WEIGHT  = 7'd11;
   localparam logic [6:0] CMD_SET_OFFSET = 7'd20;
   localparam logic [6:0] CMD_SET_WIDTH  = 7'd25;
   localparam logic [6:0] CMD_SET_DEPTH  = 7'd26;
   localparam logic [6:0] CMD_COMPUTE    = 7'd41;
   localparam logic [6:0] CMD_READ_ACC   = 7'd43;
   localparam logic [6:0] CMD_SET_START  = 7'd44;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PARAM,
      S_LOAD_W,
      S_LOAD_IN,
      S_COMPUTE,
      S_READ,
      S_CAPTURE
   } seq_state_e;

endpackage

// File: rtl/conv1d_stream_loader.sv
// Streams `count` bytes from local memory into CFU writes at dest+i; each read
// is written one cycle later, so a phase of N elements takes N+1 cycles.
module conv1d_stream_loader
   import conv1d_cfu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  run,
   input  logic [ADDR_W-1:0]     base,
   input  logic [CNT_W-1:0]      dest,
   input  logic [CNT_W-1:0]      count,
   input  logic [6:0]            cmd,
   input  logic [7:0]            mem_rdata,
   output logic                  mem_rd,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  wr_en,
   output logic [6:0]            wr_cmd,
   output logic [INT32_SIZE-1:0] wr_inp0,
   output logic [INT32_SIZE-1:0] wr_inp1,
   output logic                  last
);

   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_idx;
   logic             wr_valid;

   assign mem_rd   = run && (rd_cnt < count);
   assign mem_addr = mem_rd ? base + ADDR_W'(rd_cnt) : '0;

   assign wr_en   = wr_valid;
   assign wr_cmd  = wr_valid ? cmd : 7'd0;
   assign wr_inp0 = wr_valid ? INT32_SIZE'(dest + wr_idx) : '0;
   assign wr_inp1 = wr_valid ? {{(INT32_SIZE-8){mem_rdata[7]}}, mem_rdata} : '0;
   assign last    = wr_valid && (wr_idx == count - CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_cnt   <= '0;
         wr_idx   <= '0;
         wr_valid <= 1'b0;
      end else begin
         wr_valid <= mem_rd;
         wr_idx   <= rd_cnt;
         // Rewinding on the last write lets the next phase start back-to-back.
         if (!run || last)
            rd_cnt <= '0;
         else if (mem_rd)
            rd_cnt <= rd_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/conv1d_cfu_sequencer.sv
// Job-level sequencer for the conv1d CFU: parameter setup, weight/input
// streaming, compute and accumulator readback.
module conv1d_cfu_sequencer
   import conv1d_cfu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     cfg_in_base,
   input  logic [ADDR_W-1:0]     cfg_w_base,
   input  logic [INT32_SIZE-1:0] cfg_input_offset,
   input  logic [7:0]            cfg_depth,
   input  logic [2:0]            cfg_start_filter_x,
   input  logic                  cfg_load_weights,
   input  logic                  cfg_load_all,
   output logic                  mem_rd,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic [7:0]            mem_rdata,
   output logic                  cfu_en,
   output logic [6:0]            cfu_cmd,
   output logic [INT32_SIZE-1:0] cfu_inp0,
   output logic [INT32_SIZE-1:0] cfu_inp1,
   input  logic [INT32_SIZE-1:0] cfu_ret,
   output logic                  busy,
   output logic                  done,
   output logic [INT32_SIZE-1:0] result,
   output logic                  error
);

   seq_state_e            state, state_next;
   logic [1:0]            param_idx;
   logic [ADDR_W-1:0]     in_base_q, w_base_q;
   logic [INT32_SIZE-1:0] offset_q;
   logic [7:0]            depth_q, w_depth;
   logic [2:0]            sfx_q;
   logic                  load_w_q, load_all_q;
   logic                  wvalid;

   logic accept, depth_ok, need_w;
   logic ld_run, ld_last, ld_en;
   logic [ADDR_W-1:0]     ld_base;
   logic [CNT_W-1:0]      ld_dest, ld_count, full_count;
   logic [6:0]            ld_cmd, ld_wr_cmd;
   logic [INT32_SIZE-1:0] ld_inp0, ld_inp1;
   logic [2:0]            newest_slot;

   assign accept   = (state == S_IDLE) && start && !done;
   assign depth_ok = (cfg_depth != 8'd0) && (cfg_depth <= 8'(MAX_INPUT_CHANNELS));
   assign need_w   = load_w_q || !wvalid || (depth_q != w_depth);
   assign busy     = (state != S_IDLE);

   // The ring slot written by a partial load is the one just before the start slot.
   assign newest_slot = sfx_q + 3'd7;
   assign full_count  = CNT_W'(depth_q) * CNT_W'(KERNEL_LENGTH);

   always_comb begin
      ld_base  = in_base_q;
      ld_dest  = '0;
      ld_count = full_count;
      ld_cmd   = CMD_WR_INPUT;
      if (state == S_LOAD_W) begin
         ld_base = w_base_q;
         ld_cmd  = CMD_WR_WEIGHT;
      end else if (!load_all_q) begin
         ld_dest  = CNT_W'(newest_slot) * CNT_W'(depth_q);
         ld_count = CNT_W'(depth_q);
      end
   end

   assign ld_run = (state == S_LOAD_W) || (state == S_LOAD_IN);

   conv1d_stream_loader u_loader (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (ld_run),
      .base      (ld_base),
      .dest      (ld_dest),
      .count     (ld_count),
      .cmd       (ld_cmd),
      .mem_rdata (mem_rdata),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .wr_en     (ld_en),
      .wr_cmd    (ld_wr_cmd),
      .wr_inp0   (ld_inp0),
      .wr_inp1   (ld_inp1),
      .last      (ld_last)
   );

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cfu_en     = 1'b0;
      cfu_cmd    = 7'd0;
      cfu_inp0   = '0;
      cfu_inp1   = '0;
      case (state)
         S_IDLE: if (accept && depth_ok) state_next = S_PARAM;
         S_PARAM: begin
            cfu_en = 1'b1;
            case (param_idx)
               2'd0: begin
                  cfu_cmd  = CMD_SET_OFFSET;
                  cfu_inp1 = offset_q;
               end
               2'd1: begin
                  cfu_cmd  = CMD_SET_DEPTH;
                  cfu_inp1 = INT32_SIZE'(depth_q);
               end
               default: begin
                  cfu_cmd    = CMD_SET_START;
                  cfu_inp1   = INT32_SIZE'(sfx_q);
                  state_next = need_w ? S_LOAD_W : S_LOAD_IN;
               end
            endcase
         end
         S_LOAD_W, S_LOAD_IN: begin
            cfu_en   = ld_en;
            cfu_cmd  = ld_wr_cmd;
            cfu_inp0 = ld_inp0;
            cfu_inp1 = ld_inp1;
            if (ld_last) state_next = (state == S_LOAD_W) ? S_LOAD_IN : S_COMPUTE;
         end
         S_COMPUTE: begin
            cfu_en     = 1'b1;
            cfu_cmd    = CMD_COMPUTE;
            state_next = S_READ;
         end
         S_READ: begin
            cfu_en     = 1'b1;
            cfu_cmd    = CMD_READ_ACC;
            state_next = S_CAPTURE;
         end
         S_CAPTURE: state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         param_idx  <= 2'd0;
         in_base_q  <= '0;
         w_base_q   <= '0;
         offset_q   <= '0;
         depth_q    <= '0;
         sfx_q      <= '0;
         load_w_q   <= 1'b0;
         load_all_q <= 1'b0;
         wvalid     <= 1'b0;
         w_depth    <= '0;
         result     <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         state     <= state_next;
         done      <= 1'b0;
         param_idx <= (state == S_PARAM) ? param_idx + 2'd1 : 2'd0;
         if (accept) begin
            in_base_q  <= cfg_in_base;
            w_base_q   <= cfg_w_base;
            offset_q   <= cfg_input_offset;
            depth_q    <= cfg_depth;
            sfx_q      <= cfg_start_filter_x;
            load_w_q   <= cfg_load_weights;
            load_all_q <= cfg_load_all;
            if (!depth_ok) begin
               done   <= 1'b1;
               error  <= 1'b1;
               result <= '0;
            end
         end
         if (state == S_LOAD_W && ld_last) begin
            wvalid  <= 1'b1;
            w_depth <= depth_q;
         end
         if (state == S_CAPTURE) begin
            result <= cfu_ret;
            done   <= 1'b1;
            error  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv1d_cfu_sequencer.sv
// Directed bench: byte memory and a behavioural CFU (sum of (input+offset)*weight)
// around the sequencer, with hand-computed results and cycle counts.
module tb_conv1d_cfu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] cfg_in_base, cfg_w_base;
   logic [31:0] cfg_input_offset;
   logic [7:0]  cfg_depth;
   logic [2:0]  cfg_start_filter_x;
   logic        cfg_load_weights, cfg_load_all;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata;
   logic        cfu_en;
   logic [6:0]  cfu_cmd;
   logic [31:0] cfu_inp0, cfu_inp1, cfu_ret;
   logic        busy, done, error;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   conv1d_cfu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_in_base(cfg_in_base), .cfg_w_base(cfg_w_base),
      .cfg_input_offset(cfg_input_offset), .cfg_depth(cfg_depth),
      .cfg_start_filter_x(cfg_start_filter_x),
      .cfg_load_weights(cfg_load_weights), .cfg_load_all(cfg_load_all),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .cfu_en(cfu_en), .cfu_cmd(cfu_cmd), .cfu_inp0(cfu_inp0), .cfu_inp1(cfu_inp1),
      .cfu_ret(cfu_ret), .busy(busy), .done(done), .result(result), .error(error)
   );

   always #5 clk = ~clk;

   // Byte memory: read data valid the cycle after mem_rd.
   logic [7:0] mem [65536];
   always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

   // Behavioural CFU: uniform-weight tests make tap/slot pairing irrelevant.
   int cfu_in [1024];
   int cfu_w  [1024];
   int cfu_off, cfu_dep, cfu_acc;

   function automatic int cfu_sum(int dep, int off);
      int s = 0;
      for (int i = 0; i < 8 * dep; i++) s += (cfu_in[i] + off) * cfu_w[i];
      return s;
   endfunction

   always @(posedge clk) begin
      if (cfu_en) begin
         case (cfu_cmd)
            7'd10: cfu_in[cfu_inp0[9:0]] <= cfu_inp1;
            7'd11: cfu_w[cfu_inp0[9:0]]  <= cfu_inp1;
            7'd20: cfu_off <= cfu_inp1;
            7'd26: cfu_dep <= cfu_inp1;
            7'd41: cfu_acc <= cfu_sum(cfu_dep, cfu_off);
            7'd43: cfu_ret <= cfu_acc;
            default: ;
         endcase
      end
   end

   // Traffic monitor, cleared at the start of each job.
   int          n_w, n_in, n_en, n_rd, bad_w, zero_viol;
   int          in_min, in_max;
   logic [31:0] exp_w_val;
   always @(negedge clk) begin
      if (mem_rd) n_rd++;
      if (!cfu_en && (cfu_cmd != 0 || cfu_inp0 != 0 || cfu_inp1 != 0)) zero_viol++;
      if (cfu_en) begin
         n_en++;
         if (cfu_cmd == 7'd11) begin
            n_w++;
            if (cfu_inp1 !== exp_w_val) bad_w++;
         end
         if (cfu_cmd == 7'd10) begin
            n_in++;
            if (int'(cfu_inp0) < in_min) in_min = int'(cfu_inp0);
            if (int'(cfu_inp0) > in_max) in_max = int'(cfu_inp0);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pre);
      check({pre, "_busy"},   32'(busy),   0);
      check({pre, "_done"},   32'(done),   0);
      check({pre, "_error"},  32'(error),  0);
      check({pre, "_mem_rd"}, 32'(mem_rd), 0);
      check({pre, "_cfu_en"}, 32'(cfu_en), 0);
      check({pre, "_result"}, result,      0);
      check({pre, "_addr"},   32'(mem_addr), 0);
      check({pre, "_cmd"},    32'(cfu_cmd),  0);
      check({pre, "_inp0"},   cfu_inp0,      0);
      check({pre, "_inp1"},   cfu_inp1,      0);
   endtask

   // Job outcome, captured by run_job.
   int          done_k;
   logic [31:0] job_result;
   logic        job_error, job_busy, done_after;
   logic [6:0]  p_cmd [3];
   logic [31:0] p_inp1 [3];

   // Issues one job; abort_k != 0 stops at that cycle with rst_n driven low.
   task automatic run_job(input logic [15:0] in_base, input logic [15:0] w_base,
                          input logic [31:0] offset, input logic [7:0] depth,
                          input logic [2:0] sfx, input logic lw, input logic all,
                          input logic [31:0] wval, input int abort_k);
      n_w = 0; n_in = 0; n_en = 0; n_rd = 0; bad_w = 0;
      in_min = 1 << 30; in_max = -1;
      exp_w_val = wval;
      done_k = 0;
      @(negedge clk);
      cfg_in_base = in_base; cfg_w_base = w_base; cfg_input_offset = offset;
      cfg_depth = depth; cfg_start_filter_x = sfx;
      cfg_load_weights = lw; cfg_load_all = all;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k <= 3) begin
            p_cmd[k-1]  = cfu_cmd;
            p_inp1[k-1] = cfu_inp1;
         end
         if (abort_k != 0 && k == abort_k) begin
            rst_n = 1'b0;
            return;
         end
         if (done) begin
            done_k = k;
            break;
         end
      end
      job_result = result;
      job_error  = error;
      job_busy   = busy;
      @(negedge clk);
      done_after = done;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 1024; i++) begin cfu_in[i] = 0; cfu_w[i] = 0; end
      cfu_off = 0; cfu_dep = 0; cfu_acc = 0; cfu_ret = '0; mem_rdata = '0;
      zero_viol = 0;
      for (int i = 0; i < 8; i++) begin
         mem[16'h0100 + i] = 8'h01;
         mem[16'h0200 + i] = 8'(i + 1);
         mem[16'h0300 + i] = 8'hFF;
      end
      for (int i = 0; i < 16; i++) begin
         mem[16'h0400 + i] = 8'h01;
         mem[16'h0500 + i] = 8'h02;
      end
      mem[16'h0600] = 8'd10;
      mem[16'h0601] = 8'd20;

      rst_n = 1'b0; start = 1'b0;
      cfg_in_base = '0; cfg_w_base = '0; cfg_input_offset = '0; cfg_depth = '0;
      cfg_start_filter_x = '0; cfg_load_weights = 1'b0; cfg_load_all = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Depth 1, weights 1, inputs 1..8: 36 at cycle 7+9+9.
      run_job(16'h0200, 16'h0100, 32'd0, 8'd1, 3'd0, 1'b1, 1'b1, 32'h1, 0);
      check("a_p0_cmd",  32'(p_cmd[0]), 32'd20);
      check("a_p1_cmd",  32'(p_cmd[1]), 32'd26);
      check("a_p1_inp1", p_inp1[1],     32'd1);
      check("a_p2_cmd",  32'(p_cmd[2]), 32'd44);
      check("a_done_k",  32'(done_k),   32'd25);
      check("a_result",  job_result,    32'd36);
      check("a_error",   32'(job_error), 0);
      check("a_busy",    32'(job_busy),  0);
      check("a_pulse",   32'(done_after), 0);
      check("a_n_w",     32'(n_w),  32'd8);
      check("a_n_in",    32'(n_in), 32'd8);

      // Offset 128, no weight reload: 36 + 8*128 at cycle 7+9.
      run_job(16'h0200, 16'h0100, 32'd128, 8'd1, 3'd0, 1'b0, 1'b1, 32'h1, 0);
      check("b_p0_inp1", p_inp1[0],   32'd128);
      check("b_done_k",  32'(done_k), 32'd16);
      check("b_result",  job_result,  32'd1060);
      check("b_n_w",     32'(n_w),    32'd0);

      // Weights -1: result -36, every weight write sign-extended.
      run_job(16'h0200, 16'h0300, 32'd0, 8'd1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 0);
      check("c_result",  job_result,   32'hFFFF_FFDC);
      check("c_n_w",     32'(n_w),     32'd8);
      check("c_bad_w",   32'(bad_w),   32'd0);

      // Depth change forces a weight load: 16*2 at cycle 7+17+17.
      run_job(16'h0500, 16'h0400, 32'd0, 8'd2, 3'd0, 1'b0, 1'b1, 32'h1, 0);
      check("d_done_k",  32'(done_k), 32'd41);
      check("d_result",  job_result,  32'd32);
      check("d_n_w",     32'(n_w),    32'd16);

      // Partial load into slot 2 (addr 4,5): 14*2 + 10 + 20 at cycle 7+3.
      run_job(16'h0600, 16'h0400, 32'd0, 8'd2, 3'd3, 1'b0, 1'b0, 32'h1, 0);
      check("e_p2_inp1", p_inp1[2],    32'd3);
      check("e_done_k",  32'(done_k),  32'd10);
      check("e_result",  job_result,   32'd58);
      check("e_n_w",     32'(n_w),     32'd0);
      check("e_n_in",    32'(n_in),    32'd2);
      check("e_in_min",  32'(in_min),  32'd4);
      check("e_in_max",  32'(in_max),  32'd5);

      // Illegal depths: immediate error, no traffic.
      run_job(16'h0200, 16'h0100, 32'd0, 8'd0, 3'd0, 1'b1, 1'b1, 32'h1, 0);
      repeat (4) @(negedge clk);
      check("z_done_k", 32'(done_k),    32'd1);
      check("z_error",  32'(job_error), 32'd1);
      check("z_result", job_result,     32'd0);
      check("z_busy",   32'(job_busy),  32'd0);
      check("z_n_en",   32'(n_en),      32'd0);
      check("z_n_rd",   32'(n_rd),      32'd0);
      run_job(16'h0200, 16'h0100, 32'd0, 8'd200, 3'd0, 1'b1, 1'b1, 32'h1, 0);
      repeat (4) @(negedge clk);
      check("h_done_k", 32'(done_k),    32'd1);
      check("h_error",  32'(job_error), 32'd1);
      check("h_result", job_result,     32'd0);
      check("h_n_en",   32'(n_en),      32'd0);
      check("h_n_rd",   32'(n_rd),      32'd0);

      // Reset during LOAD_W, then a job that must reload weights anyway.
      run_job(16'h0200, 16'h0100, 32'd0, 8'd1, 3'd0, 1'b1, 1'b1, 32'h1, 6);
      @(posedge clk);
      #1 check_reset_outputs("mid");
      @(negedge clk);
      rst_n = 1'b1;
      run_job(16'h0200, 16'h0100, 32'd0, 8'd1, 3'd0, 1'b0, 1'b1, 32'h1, 0);
      check("r_n_w",    32'(n_w),   32'd8);
      check("r_done_k", 32'(done_k), 32'd25);
      check("r_result", job_result,  32'd36);

      check("idle_zero_cmd", 32'(zero_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
